// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8 - time-division demultiplexing receiver for the 8-to-1 serial
// mux path. One serial bit is sampled per enabled clock and assigned to the
// slot given by an internal slot counter that a frame-sync strobe aligns.
// The reassembled word is presented on Q with a one-cycle VALID pulse.
//
// Optional feature macro: TDM_DEMUX8_PARITY_EN
//   defined   : 9-slot frame, slot 8 carries even parity over slots 0..7,
//               SLOT is 4 bits, PERR pulses on a parity mismatch.
//   undefined : 8-slot frame, SLOT is 3 bits, PERR is constant 0.
//
// Parameters
//   LSB_FIRST  1: slot k -> Q[k]; 0: slot k -> Q[7-k]
// Ports
//   clk    in   system clock, rising edge
//   RSTb   in   synchronous active-low reset
//   ENb    in   active-low sample enable; high stalls and holds all state
//   SYNC   in   frame start, marks the current Y bit as slot 0
//   Y      in   serial data bit
//   Q      out  last complete word
//   VALID  out  one-cycle pulse when Q loads a new word
//   SLOT   out  index of the next slot to be sampled
//   ERR    out  one-cycle pulse on a frame-alignment error
//   PERR   out  one-cycle parity-error pulse (0 without parity)
//   FCNT   out  good-frame count, wrapping
// -----------------------------------------------------------------------------
module tdm_demux8 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       RSTb,
   input  logic       ENb,
   input  logic       SYNC,
   input  logic       Y,
   output logic [7:0] Q,
   output logic       VALID,
`ifdef TDM_DEMUX8_PARITY_EN
   output logic [3:0] SLOT,
`else
   output logic [2:0] SLOT,
`endif
   output logic       ERR,
   output logic       PERR,
   output logic [7:0] FCNT
);

`ifdef TDM_DEMUX8_PARITY_EN
   localparam int SW  = 4;
   localparam int NSH = 8;   // shadow holds slots 0..7, parity arrives in slot 8
   localparam logic [SW-1:0]  SLOT_ZERO = 4'd0;
   localparam logic [SW-1:0]  SLOT_ONE  = 4'd1;
   localparam logic [SW-1:0]  LAST_SLOT = 4'd8;
   localparam logic [NSH-1:0] SH_ZERO   = 8'h00;
`else
   localparam int SW  = 3;
   localparam int NSH = 7;   // shadow holds slots 0..6, slot 7 comes straight from Y
   localparam logic [SW-1:0]  SLOT_ZERO = 3'd0;
   localparam logic [SW-1:0]  SLOT_ONE  = 3'd1;
   localparam logic [SW-1:0]  LAST_SLOT = 3'd7;
   localparam logic [NSH-1:0] SH_ZERO   = 7'h00;
`endif

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

   state_t         state_r, state_n;
   logic [SW-1:0]  slot_r, slot_n;
   logic [NSH-1:0] shadow_r, shadow_n;
   logic [7:0]     q_r, q_n;
   logic [7:0]     fcnt_r, fcnt_n;
   logic           valid_r, valid_n;
   logic           err_r, err_n;
   logic [7:0]     word_s;
`ifdef TDM_DEMUX8_PARITY_EN
   logic           perr_r, perr_n;
`endif

   function automatic logic [7:0] bit_rev(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = d[7-i];
      end
      return r;
   endfunction

   // Even parity: the parity bit equals the XOR of the data bits.
   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   // Next-state, slot sequencing, shadow capture and word assembly.
   always_comb begin
      state_n  = state_r;
      slot_n   = slot_r;
      shadow_n = shadow_r;
      q_n      = q_r;
      fcnt_n   = fcnt_r;
      valid_n  = 1'b0;
      err_n    = 1'b0;
      word_s   = 8'h00;
`ifdef TDM_DEMUX8_PARITY_EN
      perr_n   = 1'b0;
`endif
      if (!ENb) begin
         case (state_r)
            HUNT: begin
               if (SYNC) begin
                  shadow_n[0] = Y;
                  slot_n      = SLOT_ONE;
                  state_n     = RUN;
               end else begin
                  state_n = HUNT;
               end
            end
            RUN: begin
               if (SYNC) begin
                  // Re-sync inside a frame: drop the partial word and restart.
                  err_n       = 1'b1;
                  shadow_n[0] = Y;
                  slot_n      = SLOT_ONE;
                  state_n     = RUN;
               end else if (slot_r == LAST_SLOT) begin
`ifdef TDM_DEMUX8_PARITY_EN
                  word_s = shadow_r;
                  if (Y == even_par(word_s)) begin
                     q_n     = LSB_FIRST ? word_s : bit_rev(word_s);
                     valid_n = 1'b1;
                     fcnt_n  = fcnt_r + 8'd1;
                  end else begin
                     perr_n = 1'b1;
                  end
`else
                  word_s  = {Y, shadow_r};
                  q_n     = LSB_FIRST ? word_s : bit_rev(word_s);
                  valid_n = 1'b1;
                  fcnt_n  = fcnt_r + 8'd1;
`endif
                  slot_n  = SLOT_ZERO;
                  state_n = HUNT;
               end else begin
                  for (int i = 0; i < NSH; i++) begin
                     shadow_n[i] = (slot_r == i[SW-1:0]) ? Y : shadow_r[i];
                  end
                  slot_n = slot_r + SLOT_ONE;
               end
            end
            default: begin
               state_n = HUNT;
               slot_n  = SLOT_ZERO;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!RSTb) begin
         state_r  <= HUNT;
         slot_r   <= SLOT_ZERO;
         shadow_r <= SH_ZERO;
         q_r      <= 8'h00;
         fcnt_r   <= 8'h00;
         valid_r  <= 1'b0;
         err_r    <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
         perr_r   <= 1'b0;
`endif
      end else begin
         state_r  <= state_n;
         slot_r   <= slot_n;
         shadow_r <= shadow_n;
         q_r      <= q_n;
         fcnt_r   <= fcnt_n;
         valid_r  <= valid_n;
         err_r    <= err_n;
`ifdef TDM_DEMUX8_PARITY_EN
         perr_r   <= perr_n;
`endif
      end
   end

   assign Q     = q_r;
   assign VALID = valid_r;
   assign SLOT  = slot_r;
   assign ERR   = err_r;
   assign FCNT  = fcnt_r;
`ifdef TDM_DEMUX8_PARITY_EN
   assign PERR  = perr_r;
`else
   assign PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
`timescale 1ns/1ps
module tb_tdm_demux8;

`ifdef TDM_DEMUX8_PARITY_EN
   localparam int NSLOT = 9;
   localparam int SW    = 4;
`else
   localparam int NSLOT = 8;
   localparam int SW    = 3;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstb, enb, sync_i, y;
   logic [7:0]    q_a, q_b, fcnt_a, fcnt_b;
   logic          valid_a, valid_b, err_a, err_b, perr_a, perr_b;
   logic [SW-1:0] slot_a, slot_b;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   tdm_demux8 #(.LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .RSTb(rstb), .ENb(enb), .SYNC(sync_i), .Y(y),
      .Q(q_a), .VALID(valid_a), .SLOT(slot_a), .ERR(err_a), .PERR(perr_a), .FCNT(fcnt_a)
   );

   tdm_demux8 #(.LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .RSTb(rstb), .ENb(enb), .SYNC(sync_i), .Y(y),
      .Q(q_b), .VALID(valid_b), .SLOT(slot_b), .ERR(err_b), .PERR(perr_b), .FCNT(fcnt_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   // Bits since the last SYNC are kept in a queue; a full queue is a frame.
   bit         m_hunt  = 1'b1;
   bit         mq[$];
   logic [7:0] m_q     = 8'h00;
   logic [7:0] m_fcnt  = 8'h00;
   logic [7:0] m_w;
   logic       m_valid = 1'b0;
   logic       m_err   = 1'b0;
   logic       m_perr  = 1'b0;
   int         m_slot  = 0;

   always @(posedge clk) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_perr  = 1'b0;
      if (!rstb) begin
         m_hunt = 1'b1;
         mq.delete();
         m_q    = 8'h00;
         m_fcnt = 8'h00;
      end else if (!enb) begin
         if (sync_i) begin
            m_err = !m_hunt;
            mq.delete();
            mq.push_back(y);
            m_hunt = 1'b0;
         end else if (!m_hunt) begin
            mq.push_back(y);
            if (mq.size() == NSLOT) begin
               for (int k = 0; k < 8; k++) m_w[k] = mq[k];
`ifdef TDM_DEMUX8_PARITY_EN
               if ((^m_w) != mq[8]) begin
                  m_perr = 1'b1;
               end else begin
                  m_q = m_w;
                  m_valid = 1'b1;
                  m_fcnt = m_fcnt + 8'd1;
               end
`else
               m_q = m_w;
               m_valid = 1'b1;
               m_fcnt = m_fcnt + 8'd1;
`endif
               mq.delete();
               m_hunt = 1'b1;
            end
         end
      end
      m_slot = m_hunt ? 0 : mq.size();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("q_lsb",  q_a,     m_q);
         chk("q_msb",  q_b,     rev8(m_q));
         chk("valid",  valid_a, m_valid);
         chk("valid_b", valid_b, m_valid);
         chk("err",    err_a,   m_err);
         chk("perr",   perr_a,  m_perr);
         chk("fcnt",   fcnt_a,  m_fcnt);
         chk("slot",   slot_a,  m_slot);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic e, input logic s, input logic d);
      enb = e; sync_i = s; y = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] w, input logic pbit,
                             input int stall_after, input int stall_len);
      for (int k = 0; k < NSLOT; k++) begin
         logic b;
         b = (k < 8) ? w[k] : pbit;
         step(1'b0, k == 0, b);
         if (k == stall_after) begin
            for (int j = 0; j < stall_len; j++) begin
               step(1'b1, 1'b0, 1'b1);
               chk("stall_slot", slot_a, stall_after + 1);
               chk("stall_valid", valid_a, 0);
            end
         end
      end
   endtask

   initial begin
      logic [7:0] a7;
      a7 = 8'hA7;
      // reset with enable and SYNC active
      rstb = 1'b0; enb = 1'b0; sync_i = 1'b1; y = 1'b1;
      @(posedge clk); #1;
      chk_on = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      chk("rst_q", q_a, 8'h00);
      chk("rst_fcnt", fcnt_a, 8'h00);
      chk("rst_slot", slot_a, 0);
      chk("rst_valid", valid_a, 0);
      rstb = 1'b1;
      step(1'b0, 1'b0, 1'b1);   // HUNT discards Y

      // basic frame 1,0,1,0,...
      send_frame(8'h55, ^8'h55, -1, 0);
      chk("basic_valid", valid_a, 1);
      chk("basic_q_lsb", q_a, 8'h55);
      chk("basic_q_msb", q_b, 8'hAA);
      chk("basic_fcnt", fcnt_a, 8'd1);
      chk("model_q", m_q, 8'h55);
      step(1'b0, 1'b0, 1'b0);
      chk("basic_pulse", valid_a, 0);
      chk("basic_hold", q_a, 8'h55);

      // stall of 3 cycles after slot 3
      send_frame(8'h01, ^8'h01, 3, 3);
      chk("stall_done", valid_a, 1);
      chk("stall_q", q_a, 8'h01);
      step(1'b1, 1'b0, 1'b0);

      // back-to-back frames after a fresh reset
      rstb = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      rstb = 1'b1;
      send_frame(8'hFB, ^8'hFB, -1, 0);
      chk("b2b1_valid", valid_a, 1);
      chk("b2b1_q", q_a, 8'hFB);
      send_frame(8'h3E, ^8'h3E, -1, 0);
      chk("b2b2_valid", valid_a, 1);
      chk("b2b2_q", q_a, 8'h3E);
      chk("b2b_fcnt", fcnt_a, 8'd2);

      // misaligned: SYNC again at slot 5
      for (int k = 0; k < 5; k++) step(1'b0, k == 0, 1'b1);
      step(1'b0, 1'b1, a7[0]);
      chk("mis_err", err_a, 1);
      chk("mis_q", q_a, 8'h3E);
      chk("mis_slot", slot_a, 1);
      for (int k = 1; k < NSLOT; k++) step(1'b0, 1'b0, (k < 8) ? a7[k] : ^a7);
      chk("mis_valid", valid_a, 1);
      chk("mis_newq", q_a, 8'hA7);
      chk("mis_fcnt", fcnt_a, 8'd3);

      // reset in the middle of a frame
      for (int k = 0; k < 3; k++) step(1'b0, k == 0, 1'b1);
      rstb = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      chk("midrst_q", q_a, 8'h00);
      chk("midrst_slot", slot_a, 0);
      rstb = 1'b1;

      // FCNT wrap after 256 good frames
      for (int i = 0; i < 256; i++) begin
         logic [7:0] w;
         w = i[7:0];
         send_frame(w, ^w, -1, 0);
         if (i == 254) chk("fcnt_255", fcnt_a, 8'd255);
      end
      chk("fcnt_wrap", fcnt_a, 8'd0);
      chk("wrap_q", q_a, 8'hFF);

`ifdef TDM_DEMUX8_PARITY_EN
      // bad parity: 8'h01 needs parity 1, send 0
      send_frame(8'h01, 1'b0, -1, 0);
      chk("perr_pulse", perr_a, 1);
      chk("perr_valid", valid_a, 0);
      chk("perr_q", q_a, 8'hFF);
      chk("perr_fcnt", fcnt_a, 8'd0);
`endif

      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Time-division demultiplexing receiver for the 8-to-1 serial mux path. It samples one serial bit per enabled clock and assigns each bit to the slot (0..7) given by an internal slot counter aligned by a frame-sync strobe. It presents the reassembled 8-bit word with a one-cycle valid pulse. It sits at the far end of the mux output line and restores the parallel data that the mux select sequence serialized.

## Interface
- `LSB_FIRST`, default 1: 1 maps slot k to `Q[k]`; 0 maps slot k to `Q[7-k]`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `RSTb` input 1: reset, synchronous, active-low.
- `ENb` input 1: sample enable, active-low. High stalls the block and all state holds.
- `SYNC` input 1: frame start. Marks the current `Y` bit as slot 0.
- `Y` input 1: serial data bit.
- `Q` output 8: last complete word.
- `VALID` output 1: one-cycle pulse when `Q` loads a new word.
- `SLOT` output 3 (4 with parity): index of the next slot to be sampled.
- `ERR` output 1: one-cycle pulse on a frame-alignment error.
- `PERR` output 1: one-cycle parity-error pulse; tied 0 without parity.
- `FCNT` output 8: count of good frames, wrapping.

## Operation
- Reset (`RSTb`=0 at a rising edge) sets the following, and overrides all other inputs:
  - state HUNT
  - `Q`=8'h00, `VALID`=0, `ERR`=0, `PERR`=0, `FCNT`=0, `SLOT`=0
  - internal shadow register = 0
- A sample cycle is any rising edge with `RSTb`=1 and `ENb`=0. With `ENb`=1, everything holds and `VALID`/`ERR`/`PERR` are 0.
- State HUNT:
  - sample cycle with `SYNC`=1: store `Y` to slot 0, set `SLOT`=1, go to RUN.
  - `SYNC`=0: `Y` is discarded.
- State RUN, sample cycle with `SYNC`=0, slot k in 1..6: store `Y` to slot k, `SLOT`=k+1.
- State RUN, slot 7 (last data slot) without parity:
  - `Q` <= {`Y`, shadow} with the bit order set by `LSB_FIRST`.
  - `VALID`=1 and `FCNT`+1.
  - `SLOT`=0, go to HUNT.
- Back-to-back frames: `SYNC`=1 on the sample cycle immediately after slot 7 starts a new frame with no gap cycle, because HUNT accepts it at once.
- Misalignment: `SYNC`=1 in RUN at slot k≠0:
  - `ERR`=1 for one cycle.
  - The partial frame is dropped, and `Q`/`FCNT` are unchanged.
  - The current `Y` is stored as slot 0 and `SLOT`=1; stay in RUN.
- `FCNT` wraps 255 -> 0 and counts only frames that load `Q`.
- `Q` holds its value between frames.
- Reset mid-frame discards the partial frame and clears `Q`.

## Timing
- `VALID` and the new `Q` are visible in the cycle after the edge that samples the last data bit.
- Latency from the `SYNC` bit to `VALID` is 8 sample cycles, or 9 with parity, with stalls added.
- `ERR` is visible in the cycle after the offending `SYNC` edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Maximum throughput is one word per 8 sample cycles (9 with parity).

## Configuration
- Macro: `TDM_DEMUX8_PARITY_EN`.
- Defined:
  - The frame is 9 slots. Slot 8 carries even parity over slots 0..7, and `SLOT` is 4 bits.
  - At slot 8, `Q`/`VALID`/`FCNT` update only if the parity matches.
  - On a parity mismatch, `PERR`=1 for one cycle and `Q`/`FCNT` are unchanged.
  - Either way, return to HUNT.
- Undefined:
  - The frame is 8 slots and `SLOT` is 3 bits.
  - `PERR` is constant 0.

## Test plan
- Reset: drive `RSTb`=0 for 2 cycles with `ENb`=0 and `SYNC`=1 -> `Q`=00, `FCNT`=0, `SLOT`=0, `VALID`=0 throughout.
- Basic frame, `LSB_FIRST`=1: `SYNC` at slot 0, `Y` sequence 1,0,1,0,1,0,1,0 -> `Q`=8'h55 and `VALID` high exactly 1 cycle, 8 cycles after `SYNC`; `FCNT`=1.
- Bit order: same stream with `LSB_FIRST`=0 -> `Q`=8'hAA.
- Stall: `ENb`=1 for 3 cycles after slot 3 of a frame carrying 8'h01 -> `SLOT` frozen at 4, `VALID` pulses 11 cycles after `SYNC`, `Q`=8'h01.
- Back-to-back and misalignment, in order:
  - two consecutive frames 8'hFB then 8'h3E -> `VALID` at 8 and 16 cycles, `FCNT`=2.
  - a third frame with `SYNC` re-asserted at slot 5 -> `ERR` pulse, `Q` stays 8'h3E, the new frame completes 8 cycles after the second `SYNC`.
- `FCNT` wrap and parity:
  - 256 good frames -> `FCNT`=0.
  - With `TDM_DEMUX8_PARITY_EN`, 8'h01 sent with parity bit 0 -> `PERR`=1, `Q` unchanged, `FCNT` unchanged.
